vga_write_arbiter: RTL

//   Shares the single VGA text-buffer write port (vga_addr/vga_we/vga_data) between
//   NUM_REQ sprite/tile FSMs (player mover, ghost movers, score painter).

---
 rtl/vga_write_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter sharing the VGA text-buffer write port among NUM_REQ requesters.
// Define VGA_WRITE_ARBITER_CLEAR_EN to add the full-screen clear engine (clear_start/clear_done).
module vga_write_arbiter #(
  parameter int                NUM_REQ      = 4,
  parameter int                ADDR_W       = 12,
  parameter int                DATA_W       = 16,
  parameter int                SCREEN_CELLS = 2400,
  parameter logic [DATA_W-1:0] CLEAR_WORD   = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         vga_addr,
  output logic                      vga_we,
  output logic [DATA_W-1:0]         vga_data,
  output logic                      busy,
  output logic                      addr_err
`ifdef VGA_WRITE_ARBITER_CLEAR_EN
  ,
  input  logic                      clear_start,
  output logic                      clear_done
`endif
);

  localparam int                PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0]   SCREEN_LIM = (ADDR_W + 1)'(SCREEN_CELLS);
  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(SCREEN_CELLS - 1);
  localparam logic [PTR_W-1:0]  LAST_REQ   = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]   ptr, ptr_nxt, win;
  logic [NUM_REQ-1:0] eligible, gnt_nxt;
  logic               found;
  logic [ADDR_W-1:0]  win_addr, vga_addr_nxt;
  logic [DATA_W-1:0]  win_data, vga_data_nxt;
  logic               win_legal, vga_we_nxt, addr_err_nxt;
  logic               clear_go, in_clear;
  logic [ADDR_W-1:0]  clr_addr;

`ifdef VGA_WRITE_ARBITER_CLEAR_EN
  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;

  assign clear_go = (state == ARB) && clear_start;
  assign in_clear = (state == CLEAR);
  assign clr_addr = clr_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      clr_cnt    <= clear_go ? '0 : (in_clear ? clr_cnt + 1'b1 : clr_cnt);
      clear_done <= in_clear && (clr_cnt == LAST_CELL);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (clear_start)           state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST_CELL)  state_nxt = ARB;
      default:                            state_nxt = ARB;
    endcase
  end
`else
  assign clear_go = 1'b0;
  assign in_clear = 1'b0;
  assign clr_addr = '0;
`endif

  // Winner: first eligible index at or after ptr; the current grantee is masked
  // so a requester presenting back-to-back writes cannot starve the others.
  always_comb begin
    eligible = req & ~gnt;
    found    = 1'b0;
    win      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && eligible[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = PTR_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

  assign win_addr  = req_addr[win*ADDR_W +: ADDR_W];
  assign win_data  = req_data[win*DATA_W +: DATA_W];
  assign win_legal = ({1'b0, win_addr} < SCREEN_LIM);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    gnt_nxt      = '0;
    vga_we_nxt   = 1'b0;
    vga_addr_nxt = vga_addr;
    vga_data_nxt = vga_data;
    ptr_nxt      = ptr;
    addr_err_nxt = addr_err;
    if (clear_go) begin
      // clear entry beats any pending request; the bus idles for this beat
    end else if (in_clear) begin
      vga_we_nxt   = 1'b1;
      vga_addr_nxt = clr_addr;
      vga_data_nxt = CLEAR_WORD;
    end else if (found) begin
      gnt_nxt[win] = 1'b1;
      vga_we_nxt   = win_legal;
      vga_addr_nxt = win_addr;
      vga_data_nxt = win_data;
      ptr_nxt      = (win == LAST_REQ) ? '0 : win + 1'b1;
      addr_err_nxt = addr_err | ~win_legal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      vga_we   <= 1'b0;
      vga_addr <= '0;
      vga_data <= '0;
      ptr      <= '0;
      addr_err <= 1'b0;
    end else begin
      gnt      <= gnt_nxt;
      vga_we   <= vga_we_nxt;
      vga_addr <= vga_addr_nxt;
      vga_data <= vga_data_nxt;
      ptr      <= ptr_nxt;
      addr_err <= addr_err_nxt;
    end
  end

  assign busy = vga_we | in_clear;

endmodule
